// File: rtl/bit_count_pkg.sv
// bit_count_pkg: shared FSM state type and sizing for the bit-count controller
package bit_count_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, SCAN, SHIFT, DONE, ERR} bc_state_t;
  localparam int BC_WIDTH = 8;
  function automatic int max_scan(input int w);
    return 2 * w + 1;
  endfunction
endpackage

// File: rtl/bit_count_watchdog.sv
// bit_count_watchdog: clear/enable counter saturating at LIMIT, flags expiry.
// The count is exported only when BIT_COUNT_PERF_EN is defined.
module bit_count_watchdog #(
  parameter int LIMIT = 17,
  parameter int CW = $clog2(LIMIT + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          en,
`ifdef BIT_COUNT_PERF_EN
  output logic [CW-1:0] cnt,
`endif
  output logic          expired
);
`ifndef BIT_COUNT_PERF_EN
  logic [CW-1:0] cnt;
`endif
  assign expired = cnt == CW'(LIMIT);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && !expired) cnt <= cnt + 1'b1;
endmodule

// File: rtl/bit_count_ctrl.sv
// bit_count_ctrl: sequences the bit-counting datapath (load, LSB-first scan, count, finish).
// BIT_COUNT_PERF_EN adds the scan_cycles output holding the final watchdog count.
module bit_count_ctrl
  import bit_count_pkg::*;
#(
  parameter int WIDTH = BC_WIDTH,
  parameter int MAX_SCAN = max_scan(WIDTH),
  localparam int CW = $clog2(MAX_SCAN + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] currA,
  output logic             ready,
  output logic             incr_result,
  output logic             A_is_zero,
  output logic             busy,
  output logic             done,
  output logic             error
`ifdef BIT_COUNT_PERF_EN
  ,
  output logic [CW-1:0]    scan_cycles
`endif
);
  bc_state_t state, nxt;
  logic armed, rise, zero, scan, active, expired, ready_q, az_q;
`ifdef BIT_COUNT_PERF_EN
  logic [CW-1:0] wd_cnt;
`endif
  assign rise = start && armed;
  assign zero = currA == '0;
  assign scan = state == SCAN;
  assign active = scan || state == SHIFT;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = rise ? LOAD : IDLE;
      LOAD:      nxt = SCAN;
      SCAN:      nxt = expired ? ERR : zero ? DONE : currA[0] ? SHIFT : SCAN;
      SHIFT:     nxt = expired ? ERR : SCAN;
      DONE, ERR: nxt = start ? state : IDLE;
      default:   nxt = IDLE;
    endcase
  end
  // armed records that start was low last cycle, so a level held through reset is not an edge
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state   <= IDLE;
      armed   <= 1'b0;
      ready_q <= 1'b0;
      az_q    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      state   <= nxt;
      armed   <= !start;
      ready_q <= nxt == LOAD;
      az_q    <= nxt inside {LOAD, DONE, ERR};
      busy    <= nxt inside {LOAD, SCAN, SHIFT};
      done    <= nxt == DONE;
      error   <= nxt == ERR;
    end
  // SCAN strobes act on the bit currently visible, so the datapath counts the bit it holds
  assign ready       = ready_q;
  assign incr_result = scan && currA[0] && !expired;
  assign A_is_zero   = az_q || (scan && zero && !expired);
  bit_count_watchdog #(.LIMIT(MAX_SCAN), .CW(CW)) u_wd (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (state == LOAD),
    .en      (active),
`ifdef BIT_COUNT_PERF_EN
    .cnt     (wd_cnt),
`endif
    .expired (expired)
  );
`ifdef BIT_COUNT_PERF_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) scan_cycles <= '0;
    else if (state == LOAD) scan_cycles <= '0;
    else if (active && nxt inside {DONE, ERR}) scan_cycles <= expired ? wd_cnt : wd_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_bit_count_ctrl.sv
// tb_bit_count_ctrl: table, random and corner-sequence checks of bit_count_ctrl with a datapath model
module tb_bit_count_ctrl;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, stuck = 1'b0;
  logic [7:0] currA, operand = '0, dp_a = '0;
  logic [3:0] dp_res = '0;
  logic ready, incr_result, A_is_zero, busy, done, error;
`ifdef BIT_COUNT_PERF_EN
  logic [4:0] scan_cycles;
`endif
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  bit_count_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start), .currA(currA),
    .ready(ready), .incr_result(incr_result), .A_is_zero(A_is_zero),
    .busy(busy), .done(done), .error(error)
`ifdef BIT_COUNT_PERF_EN
    , .scan_cycles(scan_cycles)
`endif
  );

  // datapath: load on ready, count without shifting on incr_result, shift unless held
  assign currA = stuck ? 8'h01 : dp_a;
  always @(posedge clk)
    if (ready) begin
      dp_a <= operand;
      dp_res <= '0;
    end else if (incr_result) dp_res <= dp_res + 1'b1;
    else if (!A_is_zero) dp_a <= dp_a >> 1;

  typedef struct { logic [7:0] op; int cyc; int pop; } vec_t;
  vec_t tbl[6];

  function automatic int ref_cycles(input logic [7:0] v);
    int h = -1;
    for (int i = 0; i < 8; i++) if (v[i]) h = i;
    return (v == 8'h00) ? 2 : 1 + (h + 1) + $countones(v) + 1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic edge_start();
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [7:0] op, input int exp_cyc, input int exp_pop, input string tag);
    int cyc = 0, incs = 0, viol = 0;
    operand = op;
    edge_start();
    chk($sformatf("%s load_strobes", tag), {ready, A_is_zero, busy}, 3'b111);
    while (!done && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      incs += int'(incr_result);
      if ((incr_result && (ready || A_is_zero)) || (ready && !A_is_zero) || (!busy && !done)) viol++;
    end
    chk($sformatf("%s latency", tag), cyc, exp_cyc);
    chk($sformatf("%s incr_pulses", tag), incs, exp_pop);
    chk($sformatf("%s result", tag), int'(dp_res), exp_pop);
    chk($sformatf("%s busy_err_at_done", tag), {busy, error, A_is_zero}, 3'b001);
    chk($sformatf("%s strobe_violations", tag), viol, 0);
`ifdef BIT_COUNT_PERF_EN
    chk($sformatf("%s scan_cycles", tag), int'(scan_cycles), exp_cyc - 1);
`endif
    start = 1'b0;
    @(posedge clk);
    #1;
    chk($sformatf("%s done_clear", tag), {done, busy}, 2'b00);
  endtask

  initial begin
    int cyc, incs, bad;
    logic [7:0] r;
    tbl[0] = '{8'h24, 10, 2};
    tbl[1] = '{8'h00, 2, 0};
    tbl[2] = '{8'hFF, 18, 8};
    tbl[3] = '{8'h01, 4, 1};
    tbl[4] = '{8'h80, 11, 1};
    tbl[5] = '{8'h55, 13, 4};
    #1;
    chk("reset_outputs", {ready, incr_result, A_is_zero, busy, done, error}, 0);
    start = 1'b1;
    @(negedge clk) reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("no_op_start_high_from_reset", {busy, ready, done}, 0);

    foreach (tbl[i]) run_op(tbl[i].op, tbl[i].cyc, tbl[i].pop, $sformatf("tbl%0d", i));
    for (int i = 0; i < 20; i++) begin
      r = 8'($urandom_range(0, 255));
      run_op(r, ref_cycles(r), $countones(r), $sformatf("rnd%0d_%02h", i, r));
    end

    // reset asserted mid-scan aborts without a clock edge
    operand = 8'h24;
    edge_start();
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1 chk("async_reset_midscan", {ready, incr_result, A_is_zero, busy, done, error}, 0);
    @(negedge clk) reset_n = 1'b1;
    bad = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (busy || ready || done) bad++;
    end
    chk("idle_after_reset_release", bad, 0);
    start = 1'b0;

    // datapath stuck at 0x01 trips the watchdog
    stuck = 1'b1;
    operand = 8'h5A;
    edge_start();
    cyc = 0;
    incs = 0;
    while (!error && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      incs += int'(incr_result);
    end
    chk("watchdog_latency", cyc, 19);
    chk("watchdog_incr_pulses", incs, 9);
    chk("watchdog_err_state", {error, busy, done, A_is_zero}, 4'b1001);
    repeat (3) @(posedge clk);
    #1 chk("err_held", error, 1);
    start = 1'b0;
    stuck = 1'b0;
    @(posedge clk);
    #1 chk("err_clear", {error, busy}, 2'b00);

    // start toggled while busy, then held through DONE
    operand = 8'hFF;
    edge_start();
    cyc = 0;
    repeat (3) begin
      @(posedge clk);
      cyc++;
    end
    #1 start = 1'b0;
    @(posedge clk);
    cyc++;
    #1 start = 1'b1;
    while (!done && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("toggle_no_restart_latency", cyc, 18);
    chk("toggle_result", int'(dp_res), 8);
    bad = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (!done || busy || ready) bad++;
    end
    chk("done_held_with_start", bad, 0);
    run_op(8'h24, 10, 2, "restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
